// File: rtl/axi_slave_ni_resp_depacketizer.sv
// axi_slave_ni_resp_depacketizer
// Reassembles NoC response flits into one AXI B or R record and presents it
// on the matching channel. The record {chan_bits, sid, kind} arrives LSB-first,
// PL_W payload bits per flit. Optional packet checking is enabled by defining
// AXI_RESP_DEPKT_PROTO_CHECK_EN. Without it, HEAD only clears the slice
// counter, every TAIL yields an output and proto_err is tied low.
//
// Handshake: every channel is strict valid/ready. A transfer happens on a
// rising clk edge where valid and ready are both high. Once raised, valid,
// chan and src_slave hold steady until that transfer. The inbound ready
// never depends on inbound valid in the same cycle.
module axi_slave_ni_resp_depacketizer #(
    parameter int TIDS_M       = 16,
    parameter int DATA_LANES   = 4,
    parameter int USER_WIDTH   = 2,
    parameter int EXT_MASTERS  = 4,
    parameter int EXT_SLAVES   = 2,
    parameter int FLIT_WIDTH_C = 64,
    localparam int TID_W = ((TIDS_M > 1) ? $clog2(TIDS_M) : 1) + $clog2(EXT_MASTERS),
    localparam int SID_W = (EXT_SLAVES > 1) ? $clog2(EXT_SLAVES) : 1,
    localparam int B_W   = TID_W + USER_WIDTH + 2,
    localparam int R_W   = TID_W + 8 * DATA_LANES + USER_WIDTH + 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLIT_WIDTH_C-1:0] inp_chan,
    input  logic                    inp_valid,
    output logic                    inp_ready,
    output logic [B_W-1:0]          b_chan,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [R_W-1:0]          r_chan,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [SID_W-1:0]        src_slave,
    output logic                    proto_err
);

    localparam int PL_W    = FLIT_WIDTH_C - 2;
    localparam int REC_B_W = 1 + SID_W + B_W;
    localparam int REC_R_W = 1 + SID_W + R_W;
    localparam int NF_B    = (REC_B_W + PL_W - 1) / PL_W;
    localparam int NF_R    = (REC_R_W + PL_W - 1) / PL_W;
    localparam int NF_MAX  = (NF_B > NF_R) ? NF_B : NF_R;
    localparam int CNT_W   = $clog2(NF_MAX) + 1;

`ifdef AXI_RESP_DEPKT_PROTO_CHECK_EN
    typedef enum logic [1:0] {ST_COLLECT, ST_OUT_B, ST_OUT_R, ST_DROP} state_t;
`else
    typedef enum logic [1:0] {ST_COLLECT, ST_OUT_B, ST_OUT_R} state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [REC_R_W-1:0]   rec_q, rec_d;
    logic                 b_valid_q, b_valid_d;
    logic                 r_valid_q, r_valid_d;
    logic                 rdy_en_q;
`ifdef AXI_RESP_DEPKT_PROTO_CHECK_EN
    logic                 proto_err_q, proto_err_d;
`endif

    logic                 head, tail, accept;
    logic [PL_W-1:0]      payload;
    logic [CNT_W-1:0]     wr_idx;
    logic                 wr_en;
    logic                 kind_in;
    logic                 unused_payload;

    assign head    = inp_chan[FLIT_WIDTH_C-1];
    assign tail    = inp_chan[FLIT_WIDTH_C-2];
    assign payload = inp_chan[PL_W-1:0];
    assign accept  = inp_valid & inp_ready;
    // Payload bits above the record on the final flit are don't-care.
    assign unused_payload = ^payload;

    // State register and all datapath flops; rdy_en_q keeps inp_ready low
    // through reset and for the edge that releases it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_COLLECT;
            cnt_q       <= '0;
            rec_q       <= '0;
            b_valid_q   <= 1'b0;
            r_valid_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
`ifdef AXI_RESP_DEPKT_PROTO_CHECK_EN
            proto_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rec_q       <= rec_d;
            b_valid_q   <= b_valid_d;
            r_valid_q   <= r_valid_d;
            rdy_en_q    <= 1'b1;
`ifdef AXI_RESP_DEPKT_PROTO_CHECK_EN
            proto_err_q <= proto_err_d;
`endif
        end
    end

    // Next-state: slice write, saturating counter, kind decode at TAIL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rec_d   = rec_q;
        wr_en   = 1'b0;
`ifdef AXI_RESP_DEPKT_PROTO_CHECK_EN
        proto_err_d = proto_err_q;
`endif
        // A HEAD always starts a fresh record at slice 0.
        wr_idx  = head ? '0 : cnt_q;
        // Slice 0 carries the kind bit; later slices leave it as stored.
        kind_in = (wr_idx == '0) ? payload[0] : rec_q[0];

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
`ifdef AXI_RESP_DEPKT_PROTO_CHECK_EN
                    if (!head && cnt_q == '0) begin
                        // Continuation flit with no packet open: discard up to TAIL.
                        proto_err_d = 1'b1;
                        if (!tail) begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        if (head && cnt_q != '0) begin
                            proto_err_d = 1'b1;
                        end
                        wr_en = (int'(wr_idx) < NF_R);
                        cnt_d = wr_en ? wr_idx + CNT_W'(1) : wr_idx;
                        if (tail) begin
                            cnt_d = '0;
                            if (int'(wr_idx) + 1 != (kind_in ? NF_R : NF_B)) begin
                                proto_err_d = 1'b1;
                            end else begin
                                state_d = kind_in ? ST_OUT_R : ST_OUT_B;
                            end
                        end
                    end
`else
                    wr_en = (int'(wr_idx) < NF_R);
                    cnt_d = wr_en ? wr_idx + CNT_W'(1) : wr_idx;
                    if (tail) begin
                        cnt_d   = '0;
                        state_d = kind_in ? ST_OUT_R : ST_OUT_B;
                    end
`endif
                end
            end
            ST_OUT_B: begin
                if (b_ready) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_OUT_R: begin
                if (r_ready) begin
                    state_d = ST_COLLECT;
                end
            end
`ifdef AXI_RESP_DEPKT_PROTO_CHECK_EN
            ST_DROP: begin
                if (accept && tail) begin
                    state_d = ST_COLLECT;
                end
            end
`endif
            default: state_d = ST_COLLECT;
        endcase

        for (int i = 0; i < REC_R_W; i++) begin
            if (wr_en && (i / PL_W) == int'(wr_idx)) begin
                rec_d[i] = payload[i % PL_W];
            end
        end

        b_valid_d = (state_d == ST_OUT_B);
        r_valid_d = (state_d == ST_OUT_R);
    end

    // Outputs: valids straight from flops, channel fields from the record.
    always_comb begin
        inp_ready = 1'b0;
        if (rdy_en_q) begin
`ifdef AXI_RESP_DEPKT_PROTO_CHECK_EN
            inp_ready = (state_q == ST_COLLECT) || (state_q == ST_DROP);
`else
            inp_ready = (state_q == ST_COLLECT);
`endif
        end
        b_valid   = b_valid_q;
        r_valid   = r_valid_q;
        b_chan    = rec_q[1+SID_W +: B_W];
        r_chan    = rec_q[1+SID_W +: R_W];
        src_slave = rec_q[1 +: SID_W];
`ifdef AXI_RESP_DEPKT_PROTO_CHECK_EN
        proto_err = proto_err_q;
`else
        proto_err = 1'b0;
`endif
    end

endmodule
